// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter/sequencer.
package ram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } state_t;

   typedef enum logic {
      REQ_CPU = 1'b0,
      REQ_DMA = 1'b1
   } req_id_t;

   localparam int WAIT_CNT_W    = 3;
   localparam int DEF_ADDR_BITS = 14;

   // One requester's transfer fields as seen at grant time.
   typedef struct packed {
      logic        we;
      logic        byte_op;
      logic [15:0] addr;
      logic [15:0] wdata;
   } xfer_t;

   function automatic logic addr_is_nxm(input logic [15:0] addr, input int addr_bits);
      return (addr >> addr_bits) != 16'd0;
   endfunction

   function automatic req_id_t other_id(input req_id_t id);
      return (id == REQ_CPU) ? REQ_DMA : REQ_CPU;
   endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Combinational two-way round-robin picker: on a tie the requester not granted last wins.
module ram_arb_rr
   import ram_arb_pkg::*;
(
   input  logic    req0,
   input  logic    req1,
   input  req_id_t last_grant,
   output logic    grant_valid,
   output req_id_t grant_id
);

   always_comb begin
      grant_valid = req0 | req1;
      grant_id    = REQ_CPU;
      if (req0 && req1) begin
         grant_id = other_id(last_grant);
      end else if (req1) begin
         grant_id = REQ_DMA;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one byte-addressable static RAM between a CPU port and a DMA port,
// sequencing CE_N/WE_N timing and returning a one-cycle ack (plus NXM flag) per transfer.
module ram_arbiter
   import ram_arb_pkg::*;
#(
   parameter int ADDR_BITS   = DEF_ADDR_BITS,
   parameter int WAIT_STATES = 0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req0,
   input  logic        req1,
   input  logic        we0,
   input  logic        we1,
   input  logic        byte0,
   input  logic        byte1,
   input  logic [15:0] addr0,
   input  logic [15:0] addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic        nxm0,
   output logic        nxm1,
   output logic [15:0] rdata0,
   output logic [15:0] rdata1,
   output logic [15:0] ram_a,
   output logic [15:0] ram_di,
   output logic        ram_ce_n,
   output logic        ram_we_n,
   output logic        ram_byte_op,
   input  logic [15:0] ram_do
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_STATES);

   state_t                 state_q, state_d;
   req_id_t                prio_q, prio_d;
   req_id_t                winner_q, winner_d;
   logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d;
   logic                   we_q, we_d;
   logic                   nxm_q, nxm_d;
   logic [15:0]            ram_a_q, ram_a_d;
   logic [15:0]            ram_di_q, ram_di_d;
   logic                   ram_byte_q, ram_byte_d;
   logic                   ram_ce_n_q, ram_ce_n_d;
   logic                   ram_we_n_q, ram_we_n_d;
   logic                   ack0_q, ack0_d, ack1_q, ack1_d;
   logic                   nxm0_q, nxm0_d, nxm1_q, nxm1_d;
   logic [15:0]            rdata0_q, rdata0_d, rdata1_q, rdata1_d;

   req_id_t                last_grant;
   req_id_t                grant_id;
   logic                   grant_valid;
   xfer_t                  xfer0, xfer1, sel;
   logic                   sel_nxm;
   logic [15:0]            capture;

   assign xfer0 = '{we: we0, byte_op: byte0, addr: addr0, wdata: wdata0};
   assign xfer1 = '{we: we1, byte_op: byte1, addr: addr1, wdata: wdata1};

   // prio_q names the requester favoured on the next tie; the picker wants the last winner.
   assign last_grant = other_id(prio_q);

   ram_arb_rr u_rr (
      .req0        (req0),
      .req1        (req1),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign sel     = (grant_id == REQ_DMA) ? xfer1 : xfer0;
   assign sel_nxm = addr_is_nxm(sel.addr, ADDR_BITS);
   assign capture = nxm_q ? 16'h0000 : ram_do;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         prio_q     <= REQ_CPU;
         winner_q   <= REQ_CPU;
         cnt_q      <= '0;
         we_q       <= 1'b0;
         nxm_q      <= 1'b0;
         ram_a_q    <= '0;
         ram_di_q   <= '0;
         ram_byte_q <= 1'b0;
         ram_ce_n_q <= 1'b1;
         ram_we_n_q <= 1'b1;
         ack0_q     <= 1'b0;
         ack1_q     <= 1'b0;
         nxm0_q     <= 1'b0;
         nxm1_q     <= 1'b0;
         rdata0_q   <= '0;
         rdata1_q   <= '0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         winner_q   <= winner_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         nxm_q      <= nxm_d;
         ram_a_q    <= ram_a_d;
         ram_di_q   <= ram_di_d;
         ram_byte_q <= ram_byte_d;
         ram_ce_n_q <= ram_ce_n_d;
         ram_we_n_q <= ram_we_n_d;
         ack0_q     <= ack0_d;
         ack1_q     <= ack1_d;
         nxm0_q     <= nxm0_d;
         nxm1_q     <= nxm1_d;
         rdata0_q   <= rdata0_d;
         rdata1_q   <= rdata1_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      winner_d   = winner_q;
      cnt_d      = cnt_q;
      we_d       = we_q;
      nxm_d      = nxm_q;
      ram_a_d    = ram_a_q;
      ram_di_d   = ram_di_q;
      ram_byte_d = ram_byte_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid) begin
               state_d    = ST_ACCESS;
               cnt_d      = WAIT_LOAD;
               winner_d   = grant_id;
               prio_d     = other_id(grant_id);
               we_d       = sel.we;
               nxm_d      = sel_nxm;
               ram_a_d    = sel.addr;
               ram_di_d   = sel.wdata;
               ram_byte_d = sel.byte_op;
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q - WAIT_CNT_W'(1);
            end
         end
         ST_ACK:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are computed one cycle ahead so every RAM-facing output leaves a flop.
   always_comb begin
      ram_ce_n_d = 1'b1;
      ram_we_n_d = 1'b1;
      ack0_d     = 1'b0;
      ack1_d     = 1'b0;
      nxm0_d     = 1'b0;
      nxm1_d     = 1'b0;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      case (state_q)
         ST_IDLE: begin
            if (grant_valid && !sel_nxm) begin
               ram_ce_n_d = 1'b0;
               if (WAIT_LOAD == '0) ram_we_n_d = ~sel.we;
            end
         end
         ST_ACCESS: begin
            if (cnt_q != '0) begin
               ram_ce_n_d = nxm_q;
               if (cnt_q == WAIT_CNT_W'(1) && !nxm_q) ram_we_n_d = ~we_q;
            end else if (winner_q == REQ_CPU) begin
               ack0_d = 1'b1;
               nxm0_d = nxm_q;
               if (!we_q) rdata0_d = capture;
            end else begin
               ack1_d = 1'b1;
               nxm1_d = nxm_q;
               if (!we_q) rdata1_d = capture;
            end
         end
         default: ;
      endcase
   end

   assign ack0        = ack0_q;
   assign ack1        = ack1_q;
   assign nxm0        = nxm0_q;
   assign nxm1        = nxm1_q;
   assign rdata0      = rdata0_q;
   assign rdata1      = rdata1_q;
   assign ram_a       = ram_a_q;
   assign ram_di      = ram_di_q;
   assign ram_ce_n    = ram_ce_n_q;
   assign ram_we_n    = ram_we_n_q;
   assign ram_byte_op = ram_byte_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: instance 0 has no wait states, instance 1 has three; each sits on its own RAM model.
module tb_ram_arbiter;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic [1:0]       RESET = 2'b11;
   logic [1:0]       req0 = '0, req1 = '0, we0 = '0, we1 = '0, byte0 = '0, byte1 = '0;
   logic [1:0][15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   wire  [1:0]       ack0, ack1, nxm0, nxm1, ram_ce_n, ram_we_n, ram_byte_op;
   wire  [1:0][15:0] rdata0, rdata1, ram_a, ram_di;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_dut
         logic [15:0] ram_do_w;
         logic [15:0] word_w;
         logic [15:0] wmem [8192];

         ram_arbiter #(.ADDR_BITS(14), .WAIT_STATES((gi == 0) ? 0 : 3)) dut (
            .CLK(CLK), .RESET(RESET[gi]),
            .req0(req0[gi]), .req1(req1[gi]), .we0(we0[gi]), .we1(we1[gi]),
            .byte0(byte0[gi]), .byte1(byte1[gi]), .addr0(addr0[gi]), .addr1(addr1[gi]),
            .wdata0(wdata0[gi]), .wdata1(wdata1[gi]),
            .ack0(ack0[gi]), .ack1(ack1[gi]), .nxm0(nxm0[gi]), .nxm1(nxm1[gi]),
            .rdata0(rdata0[gi]), .rdata1(rdata1[gi]),
            .ram_a(ram_a[gi]), .ram_di(ram_di[gi]), .ram_ce_n(ram_ce_n[gi]),
            .ram_we_n(ram_we_n[gi]), .ram_byte_op(ram_byte_op[gi]), .ram_do(ram_do_w)
         );

         initial for (int i = 0; i < 8192; i++) wmem[i] <= 16'h0000;

         always_comb begin
            word_w = wmem[ram_a[gi][13:1]];
            if (ram_byte_op[gi]) ram_do_w = ram_a[gi][0] ? {8'h00, word_w[15:8]} : {8'h00, word_w[7:0]};
            else                 ram_do_w = word_w;
         end

         always @(posedge CLK) begin
            if (!ram_ce_n[gi] && !ram_we_n[gi]) begin
               if (!ram_byte_op[gi])   wmem[ram_a[gi][13:1]]       <= ram_di[gi];
               else if (ram_a[gi][0])  wmem[ram_a[gi][13:1]][15:8] <= ram_di[gi][7:0];
               else                    wmem[ram_a[gi][13:1]][7:0]  <= ram_di[gi][7:0];
            end
         end
      end
   endgenerate

   // Reference model: byte-addressed memory, last read data per port, last winner.
   logic [7:0]  refmem    [2][16384];
   logic [15:0] ref_rdata [2][2];
   int          last_win  [2];
   int          n_checks = 0;
   int          n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input int p, input bit r, input bit w, input bit b,
                        input logic [15:0] a, input logic [15:0] d);
      if (p == 0) begin
         req0[k] = r; we0[k] = w; byte0[k] = b; addr0[k] = a; wdata0[k] = d;
      end else begin
         req1[k] = r; we1[k] = w; byte1[k] = b; addr1[k] = a; wdata1[k] = d;
      end
   endtask

   task automatic ref_apply(input int k, input int p, input bit w, input bit b,
                            input logic [15:0] a, input logic [15:0] d, output bit nx);
      logic [13:0] lo, ev, od;
      lo = a[13:0];
      ev = {a[13:1], 1'b0};
      od = {a[13:1], 1'b1};
      nx = (a[15:14] != 2'b00);
      if (nx) begin
         if (!w) ref_rdata[k][p] = 16'h0000;
      end else if (w) begin
         if (b) refmem[k][lo] = d[7:0];
         else begin
            refmem[k][ev] = d[7:0];
            refmem[k][od] = d[15:8];
         end
      end else begin
         ref_rdata[k][p] = b ? {8'h00, refmem[k][lo]} : {refmem[k][od], refmem[k][ev]};
      end
      last_win[k] = p;
   endtask

   function automatic logic [15:0] port_rdata(input int k, input int p);
      return (p == 0) ? rdata0[k] : rdata1[k];
   endfunction

   task automatic do_reset(input int k);
      RESET[k] = 1'b1;
      @(negedge CLK);
      check($sformatf("k%0d reset ce_n/we_n/byte", k), {ram_ce_n[k], ram_we_n[k], ram_byte_op[k]}, 3'b110);
      check($sformatf("k%0d reset ram_a", k), ram_a[k], 16'h0);
      check($sformatf("k%0d reset ram_di", k), ram_di[k], 16'h0);
      check($sformatf("k%0d reset ack/nxm", k), {ack1[k], ack0[k], nxm1[k], nxm0[k]}, 4'b0000);
      check($sformatf("k%0d reset rdata", k), {rdata1[k], rdata0[k]}, 32'h0);
      @(negedge CLK);
      RESET[k] = 1'b0;
      ref_rdata[k][0] = 16'h0;
      ref_rdata[k][1] = 16'h0;
      last_win[k] = 1;
   endtask

   task automatic xfer(input int k, input int p, input bit w, input bit b,
                       input logic [15:0] a, input logic [15:0] d);
      int ws, cyc, ce_low, we_low;
      bit got, nx;
      ws = (k == 0) ? 0 : 3;
      @(negedge CLK);
      drive(k, p, 1'b1, w, b, a, d);
      ref_apply(k, p, w, b, a, d, nx);
      cyc = 0; ce_low = 0; we_low = 0; got = 1'b0;
      while (!got && cyc < 16) begin
         @(posedge CLK);
         cyc++;
         @(negedge CLK);
         if (cyc == 1) drive(k, p, 1'b1, w, b, 16'($urandom), 16'($urandom));
         if (!ram_ce_n[k]) ce_low++;
         if (!ram_we_n[k]) we_low++;
         if (ack0[k] || ack1[k]) got = 1'b1;
      end
      check($sformatf("k%0d ack_seen", k), got, 1'b1);
      if (got) begin
         check($sformatf("k%0d latency", k), cyc, 2 + ws);
         check($sformatf("k%0d ack_port", k), {ack1[k], ack0[k]}, (p == 0) ? 2'b01 : 2'b10);
         check($sformatf("k%0d nxm", k), {nxm1[k], nxm0[k]}, nx ? ((p == 0) ? 2'b01 : 2'b10) : 2'b00);
         check($sformatf("k%0d rdata", k), port_rdata(k, p), ref_rdata[k][p]);
         check($sformatf("k%0d other_rdata", k), port_rdata(k, 1 - p), ref_rdata[k][1 - p]);
         check($sformatf("k%0d ce_low_cycles", k), ce_low, nx ? 0 : 1 + ws);
         check($sformatf("k%0d we_low_cycles", k), we_low, (w && !nx) ? 1 : 0);
      end
      $display("xfer k=%0d port=%0d we=%0d byte=%0d addr=%o wdata=%o rdata=%o nxm=%0d cycles=%0d",
               k, p, w, b, a, d, port_rdata(k, p), nx, cyc);
      drive(k, p, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      @(negedge CLK);
      check($sformatf("k%0d ack_pulse_end", k), {ack1[k], ack0[k]}, 2'b00);
      check($sformatf("k%0d rdata_hold", k), port_rdata(k, p), ref_rdata[k][p]);
   endtask

   // Both requesters hold read requests; grants must alternate, starting opposite the last winner.
   task automatic dual(input int k, input int n, input logic [15:0] a0, input logic [15:0] a1);
      int ws, cyc, exp_p, both;
      bit got, nx;
      ws = (k == 0) ? 0 : 3;
      both = 0;
      @(negedge CLK);
      drive(k, 0, 1'b1, 1'b0, 1'b0, a0, 16'h0);
      drive(k, 1, 1'b1, 1'b0, 1'b0, a1, 16'h0);
      for (int i = 0; i < n; i++) begin
         exp_p = (last_win[k] == 0) ? 1 : 0;
         ref_apply(k, exp_p, 1'b0, 1'b0, (exp_p == 0) ? a0 : a1, 16'h0, nx);
         cyc = 0; got = 1'b0;
         while (!got && cyc < 16) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
            if (ack0[k] && ack1[k]) both++;
            if (ack0[k] || ack1[k]) got = 1'b1;
         end
         check($sformatf("k%0d dual ack_seen", k), got, 1'b1);
         check($sformatf("k%0d dual spacing", k), cyc, (i == 0) ? 2 + ws : 3 + ws);
         check($sformatf("k%0d dual winner", k), {ack1[k], ack0[k]}, (exp_p == 0) ? 2'b01 : 2'b10);
         check($sformatf("k%0d dual rdata", k), port_rdata(k, exp_p), ref_rdata[k][exp_p]);
         $display("dual k=%0d grant=%0d rdata=%o cycles=%0d", k, exp_p, port_rdata(k, exp_p), cyc);
         if (i == n - 1) begin
            drive(k, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            drive(k, 1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
         end
      end
      @(negedge CLK);
      check($sformatf("k%0d dual never_both", k), both, 0);
      check($sformatf("k%0d dual idle_after", k), {ack1[k], ack0[k]}, 2'b00);
   endtask

   int          rp;
   bit          rw, rb;
   logic [15:0] ra;

   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16384; i++) refmem[k][i] = 8'h00;

      do_reset(0);
      do_reset(1);

      // Word write then read-back, no wait states.
      xfer(0, 0, 1'b1, 1'b0, 16'o000500, 16'o012706);
      xfer(0, 0, 1'b0, 1'b0, 16'o000500, 16'h0);
      check("tp word readback", rdata0[0], 16'o012706);

      // Byte write into the high lane of a zero word.
      xfer(0, 1, 1'b1, 1'b1, 16'o000701, 16'o000377);
      xfer(0, 1, 1'b0, 1'b0, 16'o000700, 16'h0);
      check("tp byte high word", rdata1[0], 16'o177400);
      xfer(0, 1, 1'b0, 1'b1, 16'o000701, 16'h0);
      check("tp byte high read", rdata1[0], 16'o000377);

      // Out-of-range read.
      xfer(0, 0, 1'b0, 1'b0, 16'o040000, 16'h0);
      check("tp nxm rdata", rdata0[0], 16'h0);

      dual(0, 4, 16'o000500, 16'o000700);

      // Three wait states.
      xfer(1, 0, 1'b1, 1'b0, 16'o001000, 16'o123456);
      xfer(1, 1, 1'b0, 1'b0, 16'o001000, 16'h0);
      check("tp ws3 readback", rdata1[1], 16'o123456);
      dual(1, 4, 16'o001000, 16'o000002);

      // Reset in the middle of a write: strobes release with no clock edge, RAM untouched.
      @(negedge CLK);
      drive(0, 0, 1'b1, 1'b1, 1'b0, 16'o000500, 16'o055555);
      @(posedge CLK);
      #2;
      check("mid pre ce_n/we_n", {ram_ce_n[0], ram_we_n[0]}, 2'b00);
      RESET[0] = 1'b1;
      #1;
      check("mid async ce_n/we_n", {ram_ce_n[0], ram_we_n[0]}, 2'b11);
      drive(0, 0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
      do_reset(0);
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("mid no_ack", {ack1[0], ack0[0]}, 2'b00);
      end
      xfer(0, 1, 1'b0, 1'b0, 16'o000500, 16'h0);
      check("mid word unchanged", rdata1[0], 16'o012706);
      do_reset(0);
      dual(0, 4, 16'o000500, 16'o000700);

      // Random single transfers against the reference model.
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 30; i++) begin
            rp = $urandom_range(0, 1);
            rw = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) ra = {2'($urandom_range(1, 3)), 14'($urandom)};
            else                           ra = 16'($urandom_range(0, 63));
            if (!rb) ra[0] = 1'b0;
            xfer(k, rp, rw, rb, ra, 16'($urandom));
         end
         dual(k, 3, 16'o000010, 16'o000020);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
